// File: rtl/fir_decim2_if.sv
// Sample stream bundle for fir_decim2: strobed CIC samples in, strobed decimated results and overrun flag out.
interface fir_decim2_if #(
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 24
);
  logic                        in_strobe;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        out_strobe;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        overrun;

  modport master (
    output in_strobe, in_data,
    input  out_strobe, out_data, overrun
  );

  modport slave (
    input  in_strobe, in_data,
    output out_strobe, out_data, overrun
  );
endinterface

// File: rtl/fir_decim2.sv
// CIC droop-compensating FIR, decimate by 2, one time-shared MAC; coefficients from COEF_INIT (h[0] in the low bits).
// Define FIR_DECIM2_ROUND_EN for round-half-up before saturation; default build truncates.
//
//   state   | meaning
//   IDLE    | waiting for a primed trigger sample
//   RUN     | TAPS cycles issuing ring address base-k and coefficient k
//   DRAIN   | 3 cycles: RAM read, product register, last accumulate
//   OUT     | out_strobe high for this cycle
module fir_decim2 #(
  parameter int IN_WIDTH   = 18,
  parameter int OUT_WIDTH  = 24,
  parameter int COEF_WIDTH = 18,
  parameter int TAPS       = 64,
  parameter logic [TAPS*COEF_WIDTH-1:0] COEF_INIT = '0,
  parameter int ACC_WIDTH  = IN_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input logic clock,
  input logic reset,
  fir_decim2_if.slave bus
);
  localparam int AW         = $clog2(TAPS);
  localparam int PROD_WIDTH = IN_WIDTH + COEF_WIDTH;
  localparam int LSB        = IN_WIDTH + COEF_WIDTH - 1 - OUT_WIDTH;
  localparam int UPPER      = ACC_WIDTH - LSB;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]                   state;
  logic [AW-1:0]                wr_ptr;
  logic [AW-1:0]                rd_ptr;
  logic [AW-1:0]                coef_addr;
  logic [AW:0]                  fill;
  logic                         phase;
  logic [1:0]                   drain_cnt;
  logic                         rd_valid;
  logic                         prod_valid;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         out_strobe_q;
  logic signed [OUT_WIDTH-1:0]  out_data_q;
  logic                         overrun_q;

  logic signed [IN_WIDTH-1:0]   ring [TAPS];
  logic signed [IN_WIDTH-1:0]   rd_q;
  logic signed [COEF_WIDTH-1:0] coef_q;
  logic signed [PROD_WIDTH-1:0] prod;

  logic                         trigger;
  logic                         start;
  logic signed [UPPER:0]        upper_rnd;
  logic [UPPER-OUT_WIDTH+1:0]   hi;
  logic signed [OUT_WIDTH-1:0]  sat_val;

  assign trigger = bus.in_strobe & phase;
  assign start   = trigger && (state == S_IDLE) && (fill >= (AW+1)'(TAPS-1));

  always_comb begin
    upper_rnd = {acc[ACC_WIDTH-1], acc[ACC_WIDTH-1:LSB]};
`ifdef FIR_DECIM2_ROUND_EN
    upper_rnd = upper_rnd + (UPPER+1)'(acc[LSB-1]);
`endif
    hi = upper_rnd[UPPER:OUT_WIDTH-1];
    if ((&hi) || (~|hi))
      sat_val = upper_rnd[OUT_WIDTH-1:0];
    else if (upper_rnd[UPPER])
      sat_val = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      sat_val = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  end

  // Sample RAM and MAC datapath registers carry no reset; validity is tracked by rd_valid/prod_valid.
  always_ff @(posedge clock) begin
    if (bus.in_strobe)
      ring[wr_ptr] <= bus.in_data;
    rd_q   <= ring[rd_ptr];
    coef_q <= COEF_INIT[coef_addr*COEF_WIDTH +: COEF_WIDTH];
    prod   <= PROD_WIDTH'(rd_q) * PROD_WIDTH'(coef_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      coef_addr    <= '0;
      fill         <= '0;
      phase        <= 1'b0;
      drain_cnt    <= '0;
      rd_valid     <= 1'b0;
      prod_valid   <= 1'b0;
      acc          <= '0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (bus.in_strobe) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= ~phase;
        if (fill != (AW+1)'(TAPS))
          fill <= fill + 1'b1;
      end
      if (trigger && (state != S_IDLE))
        overrun_q <= 1'b1;

      rd_valid   <= (state == S_RUN);
      prod_valid <= rd_valid;
      if (start)
        acc <= '0;
      else if (prod_valid)
        acc <= acc + ACC_WIDTH'(prod);

      out_strobe_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RUN;
            rd_ptr    <= wr_ptr;
            coef_addr <= '0;
          end
        end
        S_RUN: begin
          rd_ptr    <= rd_ptr - 1'b1;
          coef_addr <= coef_addr + 1'b1;
          if (coef_addr == AW'(TAPS-1)) begin
            state     <= S_DRAIN;
            drain_cnt <= 2'd2;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            state        <= S_OUT;
            out_strobe_q <= 1'b1;
            out_data_q   <= sat_val;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_strobe = out_strobe_q;
  assign bus.out_data   = out_data_q;
  assign bus.overrun    = overrun_q;
endmodule
